ram_907036_arb: RTL
===================

# ram_907036_arb

Two-port access controller for the 1K×8 synchronous playfield RAM (RAM read data is registered, one clock after the address). The CPU issues single-byte reads and writes through a request/acknowledge handshake. The motion-object DMA engine issues burst reads of 1–64 bytes. Every RAM control signal is driven from a register, and the block returns read data to whichever requester owns each slot.

## Interface
Parameters:
- CPU_PRIORITY, 1: on a same-cycle collision, 1 = CPU wins and 0 = DMA wins.
- DMA_LEN_W, 6: width of dma_len. A burst of 0 means 2^DMA_LEN_W bytes.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  10  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse: access complete; cpu_rdata valid this cycle for reads.
- cpu_rdata  out  8  read data, held until the next CPU read ack.
- dma_start  in  1  pulse to start a burst; ignored while dma_busy or clearing.
- dma_base  in  10  burst start address, sampled with dma_start.
- dma_len  in  DMA_LEN_W  burst length, sampled with dma_start.
- dma_busy  out  1  burst in progress.
- dma_valid  out  1  dma_data valid this cycle.
- dma_data  out  8  burst read byte.
- dma_last  out  1  set with the final dma_valid of a burst.
- ram_a  out  10  RAM address.
- ram_in  out  8  RAM write data.
- ram_out  in  8  RAM read data, registered inside the RAM.
- ram_cs_n  out  1  RAM select, active low.
- ram_we_n  out  1  RAM write enable, active low.
- ready  out  1  arbiter accepting requests; 0 while reset or clearing.

## Operation
- Three-stage pipeline:
  - Arbitrate (A): choose a slot owner from the registered state.
  - Issue (I): registered ram_a, ram_in, ram_cs_n and ram_we_n are driven.
  - Data (D): ram_out is valid and is routed to the owner recorded at I.
- At most one slot is issued per cycle. An idle slot drives ram_cs_n=1, ram_we_n=1, ram_a=0 and ram_in=0.
- CPU eligibility:
  - The CPU is eligible when cpu_req=1 and it has no access in I or D.
  - The CPU is therefore not eligible in the cycle where cpu_ack=1, so it has one cycle to change address or drop the request.
  - Throughput is at most one CPU access per 3 cycles.
- DMA eligibility:
  - DMA is eligible when dma_busy=1 and bytes remain to be issued.
  - The address counter increments modulo 1024 (0x3FF wraps to 0x000).
- Collision: both eligible → winner set by CPU_PRIORITY. The loser retries the next cycle; no state is lost.
- Writes:
  - A CPU write is committed at the end of its I cycle.
  - cpu_ack is asserted in D, the same position as for a read.
  - cpu_rdata is unchanged on a write.
- Burst state machine: IDLE → BURST on an accepted dma_start (base and len latched). BURST → IDLE in the cycle after dma_last.
- dma_busy:
  - Goes high the cycle after dma_start is accepted.
  - Goes low the cycle after dma_last.
- Reset:
  - Clears all pipeline stages.
  - Aborts the burst; no further dma_valid or dma_last.
  - Drops any pending cpu_ack; the CPU re-requests.
- Reset values: cpu_ack=0, cpu_rdata=0, dma_busy=0, dma_valid=0, dma_data=0, dma_last=0, ram_a=0, ram_in=0, ram_cs_n=1, ram_we_n=1.

## Timing
- CPU read latency: cpu_req is first seen high at cycle 0 with no contention.
  - Cycle 1: ram_a = cpu_addr (I).
  - Cycle 2: cpu_ack=1 with cpu_rdata = ram[cpu_addr].
- Each lost collision adds 1 cycle.
- DMA latency:
  - dma_start at cycle 0.
  - Cycle 1: dma_busy=1; the first address is arbitrated.
  - Cycle 2: first I.
  - Cycle 3: first dma_valid.
- An uncontended burst of N bytes produces dma_valid on N consecutive cycles.
- A CPU write at I cycle k is visible to a DMA read whose I cycle is k+1 or later. The same ordering holds for the reverse case: the RAM is written at the posedge ending cycle k, and a read issued in cycle k returns the old data.

## Configuration
- RAM_ARB_CLEAR_EN defined:
  - After reset deasserts, the block writes 0x00 to addresses 0..1023, one per cycle, ascending.
  - During the sweep, ready=0 and all CPU and DMA requests are held off.
  - ready rises in the cycle after the write to 0x3FF is issued.
  - Reset during the sweep restarts it at address 0.
- RAM_ARB_CLEAR_EN undefined:
  - No sweep; RAM contents are undefined after reset.
  - ready=1 from the first cycle after reset deasserts.

## Test plan
- Single CPU access: CPU write 0x5A to 0x123, then read 0x123 → cpu_ack 2 cycles after each request; the read returns cpu_rdata=0x5A.
- Full burst with wrap: preload 0x3FE=0x11, 0x3FF=0x22, 0x000=0x33; dma_start base=0x3FE len=3 → dma_valid on 3 consecutive cycles with data 0x11, 0x22, 0x33; dma_last on the third; dma_busy low one cycle later.
- Collision: CPU_PRIORITY=1, burst of len=0 (64 bytes) running, CPU reads repeatedly → every CPU ack at exactly 2 cycles; the burst completes with all 64 bytes in order, taking 64 cycles plus one per CPU grant.
- Start while busy: dma_start during an active burst → ignored; the original burst's length and data are unchanged.
- Reset mid-burst: reset asserted at the 5th dma_valid → no further dma_valid or dma_last, dma_busy=0 and ram_cs_n=1 the cycle after; a new burst starts normally.
- Clear sweep (RAM_ARB_CLEAR_EN defined): fill the RAM with 0xFF, reset → ready=0 for 1024 cycles; afterwards, a read of 0x000, 0x200 and 0x3FF returns 0x00; cpu_req held during the sweep is acked only after ready=1.

Source files
------------

// File: rtl/ram_907036_arb_if.sv
// Requester-side bundle for ram_907036_arb: CPU single-byte handshake
// and DMA burst port. master = requester, slave = arbiter.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> ; <- cpu_ack/cpu_rdata
//   dma_start/dma_base/dma_len -> ; <- dma_busy/dma_valid/dma_data/dma_last
interface ram_907036_arb_if #(
   parameter int DMA_LEN_W = 6
);
   logic                 cpu_req;
   logic                 cpu_we;
   logic [9:0]           cpu_addr;
   logic [7:0]           cpu_wdata;
   logic                 cpu_ack;
   logic [7:0]           cpu_rdata;
   logic                 dma_start;
   logic [9:0]           dma_base;
   logic [DMA_LEN_W-1:0] dma_len;
   logic                 dma_busy;
   logic                 dma_valid;
   logic [7:0]           dma_data;
   logic                 dma_last;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_start, dma_base, dma_len,
      input  cpu_ack, cpu_rdata,
      input  dma_busy, dma_valid, dma_data, dma_last
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_start, dma_base, dma_len,
      output cpu_ack, cpu_rdata,
      output dma_busy, dma_valid, dma_data, dma_last
   );
endinterface

// File: rtl/ram_907036_arb.sv
// CPU/DMA access controller for a 1Kx8 synchronous RAM (A->I->D pipeline).
// Ports: clk, reset (sync, high), bus (ram_907036_arb_if.slave),
//   ram_a/ram_in/ram_cs_n/ram_we_n (registered), ram_out, ready.
// Optional macro RAM_ARB_CLEAR_EN: zero-fill sweep of the RAM after reset.
module ram_907036_arb #(
   parameter bit CPU_PRIORITY = 1'b1,
   parameter int DMA_LEN_W    = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   ram_907036_arb_if.slave        bus,
   output logic [9:0]             ram_a,
   output logic [7:0]             ram_in,
   input  logic [7:0]             ram_out,
   output logic                   ram_cs_n,
   output logic                   ram_we_n,
   output logic                   ready
);
   localparam int CW = DMA_LEN_W + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state, state_nxt;
   logic [9:0]    dma_addr;
   logic [CW-1:0] dma_rem;
   logic          clr_act;
   logic [9:0]    clr_addr;
   logic          i_cpu, i_dma, i_we, i_last;
   logic          d_cpu, d_dma, d_we, d_last;
   logic [7:0]    rdata_q, ddata_q;
   logic          cpu_elig, dma_elig;
   logic          grant_cpu, grant_dma;
   logic          start_ok, burst_end;
   logic [9:0]    a_nxt;
   logic [7:0]    in_nxt;
   logic          cs_nxt, we_nxt;

`ifdef RAM_ARB_CLEAR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_act  <= 1'b1;
         clr_addr <= 10'd0;
      end else if (clr_act) begin
         clr_addr <= clr_addr + 10'd1;
         if (clr_addr == 10'h3FF) clr_act <= 1'b0;
      end
   end
`else
   assign clr_act  = 1'b0;
   assign clr_addr = 10'd0;
`endif

   assign ready = ~reset & ~clr_act;

   // CPU may not re-enter while its previous access is still in I or D.
   assign cpu_elig  = ready & bus.cpu_req & ~i_cpu & ~d_cpu;
   assign dma_elig  = ready & (state == BURST) & (dma_rem != '0);
   assign grant_cpu = cpu_elig & (CPU_PRIORITY | ~dma_elig);
   assign grant_dma = dma_elig & ~grant_cpu;
   assign start_ok  = ready & bus.dma_start & (state == IDLE);
   assign burst_end = d_dma & d_last;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start_ok)  state_nxt = BURST;
         BURST: if (burst_end) state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.dma_busy = (state == BURST);
   end

   // dma_rem counts bytes still to issue; len 0 means a full 2^W burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         dma_addr <= 10'd0;
         dma_rem  <= '0;
      end else if (start_ok) begin
         dma_addr <= bus.dma_base;
         dma_rem  <= (bus.dma_len == '0) ? {1'b1, {DMA_LEN_W{1'b0}}}
                                         : {1'b0, bus.dma_len};
      end else if (grant_dma) begin
         dma_addr <= dma_addr + 10'd1;
         dma_rem  <= dma_rem - CW'(1);
      end
   end

   always_comb begin
      a_nxt  = 10'd0;
      in_nxt = 8'h00;
      cs_nxt = 1'b1;
      we_nxt = 1'b1;
      unique case (1'b1)
         clr_act: begin
            a_nxt  = clr_addr;
            cs_nxt = 1'b0;
            we_nxt = 1'b0;
         end
         grant_cpu: begin
            a_nxt  = bus.cpu_addr;
            in_nxt = bus.cpu_we ? bus.cpu_wdata : 8'h00;
            cs_nxt = 1'b0;
            we_nxt = ~bus.cpu_we;
         end
         grant_dma: begin
            a_nxt  = dma_addr;
            cs_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ram_a    <= 10'd0;
         ram_in   <= 8'h00;
         ram_cs_n <= 1'b1;
         ram_we_n <= 1'b1;
         i_cpu    <= 1'b0;
         i_dma    <= 1'b0;
         i_we     <= 1'b0;
         i_last   <= 1'b0;
         d_cpu    <= 1'b0;
         d_dma    <= 1'b0;
         d_we     <= 1'b0;
         d_last   <= 1'b0;
      end else begin
         ram_a    <= a_nxt;
         ram_in   <= in_nxt;
         ram_cs_n <= cs_nxt;
         ram_we_n <= we_nxt;
         i_cpu    <= grant_cpu;
         i_dma    <= grant_dma;
         i_we     <= grant_cpu & bus.cpu_we;
         i_last   <= grant_dma & (dma_rem == CW'(1));
         d_cpu    <= i_cpu;
         d_dma    <= i_dma;
         d_we     <= i_we;
         d_last   <= i_last;
      end
   end

   // ram_out is only valid in D; hold copies for the quiet cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= 8'h00;
         ddata_q <= 8'h00;
      end else begin
         if (d_cpu & ~d_we) rdata_q <= ram_out;
         if (d_dma)         ddata_q <= ram_out;
      end
   end

   assign bus.cpu_ack   = d_cpu;
   assign bus.cpu_rdata = (d_cpu & ~d_we) ? ram_out : rdata_q;
   assign bus.dma_valid = d_dma;
   assign bus.dma_last  = d_dma & d_last;
   assign bus.dma_data  = d_dma ? ram_out : ddata_q;
endmodule
